mesh_edge_loopback: RTL and testbench

Endpoint that terminates one dangling north/south link on a mesh row edge: `snso`/`sndo`/`snro` on the sink side and `nssi`/`nsdi`/`nsri` on the source side. It absorbs packets the edge router sends outward into a FIFO. When configured for loopback, it re-injects them into the same router, gated by virtual-channel polarity. This lets a single row (for example, row 0) be exercised standalone, with its top-side ports closed by live handshakes instead of ground.

---
 rtl/mesh_edge_loopback.sv | 134 +++++++++++++
 tb/tb_mesh_edge_loopback.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_edge_loopback.sv
// mesh_edge_loopback
//
// Terminates one dangling north/south link on a mesh row edge. Packets the
// edge router sends outward are absorbed into a small FIFO. With loopback
// enabled they are re-injected into the same router. A head packet is only
// offered while its VC bit (MSB) matches an internal polarity bit that flips
// every cycle. Without loopback the FIFO drains itself one entry per cycle
// and the block is a pure counting sink.
//
// Optional feature macro: EDGE_LOOPBACK_EN
//   defined   : loopback transmit path toward the router is live
//   undefined : tx_s/tx_d tied to 0, tx_r ignored, FIFO drains internally
//
// Handshake (both directions): a transfer happens at a rising clk edge where
// the strobe (rx_s / tx_s) and the ready (rx_r / tx_r) are both high. The
// sender holds its packet until it is taken. rx_r, tx_s and tx_d are derived
// from registered state only, so no input reaches an output combinationally.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   rx_s          in   send strobe from router (snso)
//   rx_d          in   packet from router (sndo)
//   rx_r          out  ready to router (snro)
//   tx_s          out  send strobe to router (nssi)
//   tx_d          out  packet to router (nsdi), 0 when tx_s is low
//   tx_r          in   router ready (nsri)
//   polarity_out  out  internal VC polarity
//   rx_count      out  packets accepted (wraps)
//   tx_count      out  packets sent or drained (wraps)
//   occupancy     out  current FIFO fill level

module mesh_edge_loopback #(
    parameter int PACKET_WIDTH = 64,
    parameter int DEPTH        = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_s,
    input  logic [PACKET_WIDTH-1:0]    rx_d,
    output logic                       rx_r,
    output logic                       tx_s,
    output logic [PACKET_WIDTH-1:0]    tx_d,
    input  logic                       tx_r,
    output logic                       polarity_out,
    output logic [CNT_WIDTH-1:0]       rx_count,
    output logic [CNT_WIDTH-1:0]       tx_count,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [PACKET_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           wr_ptr;
    logic [AW:0]             occ;
    logic                    pol;
    logic [CNT_WIDTH-1:0]    rx_cnt;
    logic [CNT_WIDTH-1:0]    tx_cnt;

    logic                    empty;
    logic [PACKET_WIDTH-1:0] head;
    logic                    push;
    logic                    pop;

    assign empty = (occ == '0);
    assign head  = mem[rd_ptr];

    // Ready looks only at the registered fill level: a pop in the same cycle
    // does not open the slot until the next cycle.
    assign rx_r = (occ != FULL_LEVEL);
    assign push = rx_s && rx_r;

`ifdef EDGE_LOOPBACK_EN
    // A head whose VC bit disagrees with pol waits for the next flip; packets
    // behind it are never allowed to overtake.
    assign tx_s = !empty && (head[PACKET_WIDTH-1] == pol);
    assign tx_d = tx_s ? head : '0;
    assign pop  = tx_s && tx_r;
`else
    logic unused_tx_path;

    assign tx_s = 1'b0;
    assign tx_d = '0;
    // Counting sink: drop the oldest entry every cycle something is stored.
    assign pop  = !empty;
    assign unused_tx_path = tx_r ^ (^head);
`endif

    // Storage is deliberately not reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            pol    <= 1'b0;
            rx_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            pol <= ~pol;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rx_cnt <= rx_cnt + 1'b1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                tx_cnt <= tx_cnt + 1'b1;
            end

            // Separate up/down level so full and empty need no pointer compare.
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign polarity_out = pol;
    assign rx_count     = rx_cnt;
    assign tx_count     = tx_cnt;
    assign occupancy    = occ;

endmodule

// File: tb/tb_mesh_edge_loopback.sv
// Testbench for mesh_edge_loopback. The reference model is a packet queue
// plus a polarity bit and two counters, advanced once per clock from the
// transfer rules. Inputs change on the falling edge and outputs are sampled
// 1 ns later, away from the rising edge.

module tb_mesh_edge_loopback;

    localparam int PW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          rx_s;
    logic [PW-1:0] rx_d;
    logic          rx_r;
    logic          tx_s;
    logic [PW-1:0] tx_d;
    logic          tx_r;
    logic          polarity_out;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic [OW-1:0] occupancy;

    mesh_edge_loopback #(
        .PACKET_WIDTH (PW),
        .DEPTH        (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_s         (rx_s),
        .rx_d         (rx_d),
        .rx_r         (rx_r),
        .tx_s         (tx_s),
        .tx_d         (tx_d),
        .tx_r         (tx_r),
        .polarity_out (polarity_out),
        .rx_count     (rx_count),
        .tx_count     (tx_count),
        .occupancy    (occupancy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model state ----------------
    int            checks   = 0;
    int            failures = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] sent_q[$];
    logic [PW-1:0] got_q[$];
    logic          m_pol;
    logic [CW-1:0] m_rx;
    logic [CW-1:0] m_tx;

    task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        sent_q.delete();
        got_q.delete();
        m_pol = 1'b0;
        m_rx  = '0;
        m_tx  = '0;
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a falling edge: applies inputs, checks outputs against
    // the model, crosses one rising edge, advances the model, returns at the
    // next falling edge.
    task automatic step(input logic s, input logic [PW-1:0] d, input logic r,
                        output logic acc, output logic popped);
        logic          e_rxr;
        logic          e_txs;
        logic [PW-1:0] e_txd;
        e_rxr = (exp_q.size() != DEPTH);
        e_txs = 1'b0;
        e_txd = '0;
`ifdef EDGE_LOOPBACK_EN
        if (exp_q.size() != 0) begin
            if (exp_q[0][PW-1] == m_pol) begin
                e_txs = 1'b1;
                e_txd = exp_q[0];
            end
        end
`endif
        rx_s = s;
        rx_d = d;
        tx_r = r;
        #1;
        check_eq("rx_r", rx_r, e_rxr);
        check_eq("tx_s", tx_s, e_txs);
        check_eq("tx_d", tx_d, e_txd);
        check_eq("polarity", polarity_out, m_pol);
        check_eq("rx_count", rx_count, m_rx);
        check_eq("tx_count", tx_count, m_tx);
        check_eq("occupancy", occupancy, exp_q.size());
        if (tx_s) check_eq("tx_vc_vs_pol", tx_d[PW-1], polarity_out);

        acc = s && e_rxr;
`ifdef EDGE_LOOPBACK_EN
        popped = e_txs && r;
        if (popped) got_q.push_back(tx_d);
`else
        popped = (exp_q.size() != 0);
`endif
        @(posedge clk);
        if (popped) begin
            void'(exp_q.pop_front());
            m_tx++;
        end
        if (acc) begin
            exp_q.push_back(d);
            sent_q.push_back(d);
            m_rx++;
        end
        m_pol = ~m_pol;
        @(negedge clk);
    endtask

    // Router side holds its packet until it is accepted (bounded).
    task automatic push_wait(input logic [PW-1:0] d, input logic r);
        logic acc;
        logic popped;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            step(1'b1, d, r, acc, popped);
            n++;
        end
        check_eq("push_accepted", acc, 1'b1);
    endtask

    task automatic drain(input logic r);
        logic acc;
        logic popped;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step(1'b0, '0, r, acc, popped);
            n++;
        end
        check_eq("drain_occupancy", occupancy, 0);
    endtask

    // Called just after a falling edge; reset is raised mid-cycle.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        rx_s  = 1'b0;
        rx_d  = '0;
        tx_r  = 1'b0;
        #1;
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_rx_r", rx_r, 1'b1);
        check_eq("rst_tx_s", tx_s, 1'b0);
        check_eq("rst_tx_d", tx_d, 0);
        check_eq("rst_rx_count", rx_count, 0);
        check_eq("rst_tx_count", tx_count, 0);
        check_eq("rst_polarity", polarity_out, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_eq("rel_polarity", polarity_out, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic          acc;
        logic          popped;
        logic          have;
        logic [PW-1:0] pd;
        logic [PW-1:0] p5;

        reset = 1'b1;
        rx_s  = 1'b0;
        rx_d  = '0;
        tx_r  = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Reset with two entries queued.
        step(1'b1, {$urandom, $urandom}, 1'b0, acc, popped);
        step(1'b1, {$urandom, $urandom}, 1'b0, acc, popped);
        do_reset();
        // First edge after release must flip polarity to 1.
        step(1'b0, '0, 1'b0, acc, popped);
        check_eq("pol_after_first_edge", polarity_out, 1'b1);

`ifdef EDGE_LOOPBACK_EN
        // Basic loopback of a VC=1 packet.
        do_reset();
        push_wait(64'h8000_0000_0000_00A5, 1'b1);
        drain(1'b1);
        check_eq("basic_tx_count", tx_count, 1);
        check_eq("basic_order_n", got_q.size(), 1);
        if (got_q.size() == 1) check_eq("basic_tx_d", got_q[0], 64'h8000_0000_0000_00A5);

        // Fill to DEPTH with tx_r low; the 5th packet is held.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pd = {$urandom, $urandom};
            push_wait(pd, 1'b0);
        end
        check_eq("fill_rx_r", rx_r, 1'b0);
        check_eq("fill_rx_count", rx_count, 4);
        check_eq("fill_occupancy", occupancy, 4);
        p5 = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, p5, 1'b0, acc, popped);
            check_eq("fill_held", acc, 1'b0);
        end

        // Full with simultaneous pop: slot opens one cycle later.
        popped = 1'b0;
        for (int i = 0; i < 4 && !popped; i++) begin
            step(1'b1, p5, 1'b1, acc, popped);
            check_eq("full_no_accept", acc, 1'b0);
        end
        check_eq("full_pop_seen", popped, 1'b1);
        step(1'b1, p5, 1'b0, acc, popped);
        check_eq("full_accept_next", acc, 1'b1);
        check_eq("full_rx_count", rx_count, 5);
        drain(1'b1);

        // Ordering across pointer wrap with alternating VC bits.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            pd = {$urandom, $urandom};
            pd[PW-1] = i[0];
            push_wait(pd, 1'b1);
        end
        drain(1'b1);
        check_eq("order_rx_count", rx_count, 10);
        check_eq("order_tx_count", tx_count, 10);
        check_eq("order_n", got_q.size(), sent_q.size());
        for (int i = 0; i < 10 && i < got_q.size() && i < sent_q.size(); i++)
            check_eq("order_pkt", got_q[i], sent_q[i]);
`else
        // Counting sink: three packets, tx_s checked low every cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pd = {$urandom, $urandom};
            push_wait(pd, 1'(($urandom_range(0, 1))));
        end
        drain(1'b0);
        check_eq("sink_tx_count", tx_count, 3);
        check_eq("sink_rx_count", rx_count, 3);
        check_eq("sink_tx_s", tx_s, 1'b0);
`endif

        // Randomized traffic against the model.
        do_reset();
        have = 1'b0;
        pd   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have && $urandom_range(0, 2) != 0) begin
                have = 1'b1;
                pd   = {$urandom, $urandom};
            end
            step(have, have ? pd : '0, ($urandom_range(0, 3) != 0), acc, popped);
            if (acc) have = 1'b0;
        end
        drain(1'b1);
`ifdef EDGE_LOOPBACK_EN
        check_eq("rand_order_n", got_q.size(), sent_q.size());
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
            check_eq("rand_order_pkt", got_q[i], sent_q[i]);
`endif
        check_eq("rand_counts_equal", rx_count, tx_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
